finalproject_soc_onchip_mem_arbiter: RTL and testbench
======================================================

# finalproject_soc_onchip_mem_arbiter

Two-requester round-robin arbiter that shares the single-port 4-word × 32-bit on-chip RAM (finalproject_soc_onchip_memory2_0) between two Avalon-MM style masters, e.g. the NIOS data master and the game-logic/VGA engine. It serialises accesses onto the RAM's single port, generates per-requester waitrequest/readdatavalid, and accounts for the RAM's 1-cycle read latency (registered address, unregistered q). It sits between the masters and the RAM instance inside the SoC.

## Interface
- ADDR_W, 2, word address width (RAM depth 4)
- DATA_W, 32, data width; byteenable width is DATA_W/8

- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- m0_address / m1_address  in  ADDR_W  word address
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes for writes
- m0_read / m1_read  in  1  read request, held until accepted
- m0_write / m1_write  in  1  write request, held until accepted
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_waitrequest / m1_waitrequest  out  1  high = request not yet accepted
- m0_readdata / m1_readdata  out  DATA_W  read data, qualified by readdatavalid
- m0_readdatavalid / m1_readdatavalid  out  1  one-cycle read return strobe
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  DATA_W/8  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_clken  out  1  to RAM clken, constant 1
- mem_readdata  in  DATA_W  from RAM readdata

## Operation
- FSM states: IDLE, ISSUE, RDATA.
- IDLE: if any request (read|write) pending, select winner, register grant (gnt) and its address/byteenable/writedata/op; -> ISSUE. Else stay.
- Arbitration: round-robin over 2; on simultaneous requests, winner = requester not granted last; last_grant resets to 1 (m0 wins first contest). Lone requester always wins.
- ISSUE: mem_chipselect=1, mem_write=op_is_write, mem outputs from registered command; granted waitrequest=0 for exactly this cycle. Write -> IDLE; read -> RDATA.
- RDATA: granted readdatavalid=1, readdata = mem_readdata; -> IDLE.
- m*_readdata driven with mem_readdata for both requesters; only readdatavalid distinguishes.
- read & write asserted together by one requester: illegal; treated as write.
- Requester must hold command stable while waitrequest=1; arbiter samples command only in IDLE.
- Non-granted requester keeps waitrequest=1 throughout.

## Timing
- Reset values (async, reset_n=0): state=IDLE, last_grant=1, gnt=0; m*_waitrequest=1, m*_readdatavalid=0, mem_chipselect=0, mem_write=0, mem_address/byteenable/writedata=0, mem_clken=1.
- Request first seen in IDLE at cycle N: ISSUE (accept, RAM strobe) at N+1.
- Write: RAM updated at end of N+1; next command may be sampled at N+2. Throughput 1 write / 2 cycles.
- Read: readdatavalid and data at N+2; next sample at N+3. Throughput 1 read / 3 cycles.
- Back-to-back contention: m0 and m1 both requesting continuously alternate grants, strictly 0,1,0,1...
- Reset asserted mid-ISSUE or RDATA: immediate return to reset values; an in-flight read returns no readdatavalid; an in-flight write may or may not land in RAM.
- Address wraps naturally in ADDR_W bits; no range check.

## Structure
- Shared package finalproject_soc_arb_pkg: state enum (IDLE, ISSUE, RDATA), ADDR_W/DATA_W defaults, op encoding (OP_READ, OP_WRITE).
- One sub-module natural: finalproject_soc_rr_arb2 (2-way round-robin selector with last_grant register, combinational grant out, update strobe in). All else in the top.

## Test plan
- Reset: hold reset_n=0 mid-stream -> all outputs at reset values, both waitrequest=1, mem_clken=1.
- Single write then read: m0 writes 0xDEADBEEF to addr 2, be=0xF -> waitrequest low one cycle at N+1; m0 reads addr 2 -> readdatavalid at N+2 with 0xDEADBEEF.
- Byte enables: write 0x11223344 to addr 1, then m1 writes 0xAABBCCDD with be=0x3 -> read addr 1 returns 0x1122CCDD.
- Contention: m0 and m1 both request continuously from reset -> grant order m0,m1,m0,m1; no starvation; each accepted exactly once per request.
- Read-data routing: m0 reads addr 0 while m1 waits to read addr 3 (distinct contents) -> only m0_readdatavalid pulses with addr 0 data, then m1_readdatavalid with addr 3 data three cycles later.
- Reset mid-read: assert reset_n=0 in ISSUE of a read -> no readdatavalid afterward; first post-reset contest won by m0.

Source files
------------

// File: rtl/finalproject_soc_arb_pkg.sv
// Shared definitions for the on-chip RAM arbiter slice.
//   state_t  : arbiter FSM states (IDLE, ISSUE, RDATA)
//   op_t     : registered command type (OP_READ, OP_WRITE)
//   ADDR_W_DEF / DATA_W_DEF : default word-address and data widths
//   be_width : byteenable width for a given data width
package finalproject_soc_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 2;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  function automatic int unsigned be_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/finalproject_soc_onchip_mem_arbiter_if.sv
// Avalon-MM style requester port bundle.
//   master modport : the requester (drives address/byteenable/read/write/writedata)
//   slave  modport : the arbiter   (drives waitrequest/readdata/readdatavalid)
interface finalproject_soc_onchip_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/finalproject_soc_rr_arb2.sv
// Two-way round-robin selector.
//   req[1:0]  : pending requests (bit 0 = m0, bit 1 = m1)
//   update    : commit the current grant into last_grant
//   gnt       : combinational winner index
//   gnt_valid : at least one request pending
// last_grant resets to 1 so that m0 wins the first contest.
module finalproject_soc_rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic       gnt,
  output logic       gnt_valid
);

  logic last_grant;

  always_comb begin
    gnt = 1'b0;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_grant;
      default: gnt = 1'b0;
    endcase
  end

  assign gnt_valid = |req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= gnt;
    end
  end

endmodule

// File: rtl/finalproject_soc_onchip_mem_arbiter.sv
// Round-robin arbiter sharing a single-port on-chip RAM between two
// Avalon-MM style requesters.
//   clk, reset_n : clock, asynchronous active-low reset
//   m0, m1       : requester ports (slave side of the port bundle)
//   mem_*        : RAM port; RAM has a registered address and unregistered q,
//                  so read data is valid the cycle after the ISSUE strobe.
// Each command takes IDLE -> ISSUE (-> RDATA for reads) -> IDLE; all RAM
// strobes and handshake outputs are registered.
module finalproject_soc_onchip_mem_arbiter
  import finalproject_soc_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  finalproject_soc_onchip_mem_arbiter_if.slave m0,
  finalproject_soc_onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  state_t state;
  op_t    op;
  logic   gnt;
  logic [1:0] waitreq;
  logic [1:0] rd_valid;

  logic [1:0] req;
  logic       sel;
  logic       sel_valid;
  logic       arb_update;

  logic [ADDR_W-1:0]   cmd_address;
  logic [DATA_W/8-1:0] cmd_byteenable;
  logic [DATA_W-1:0]   cmd_writedata;
  op_t                 cmd_op;

  assign req        = {m1.read | m1.write, m0.read | m0.write};
  assign arb_update = (state == IDLE) && sel_valid;

  finalproject_soc_rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .update    (arb_update),
    .gnt       (sel),
    .gnt_valid (sel_valid)
  );

  // Winner's command; read+write together is treated as a write.
  assign cmd_address    = sel ? m1.address    : m0.address;
  assign cmd_byteenable = sel ? m1.byteenable : m0.byteenable;
  assign cmd_writedata  = sel ? m1.writedata  : m0.writedata;
  assign cmd_op         = (sel ? m1.write : m0.write) ? OP_WRITE : OP_READ;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      op             <= OP_READ;
      gnt            <= 1'b0;
      waitreq        <= '1;
      rd_valid       <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_writedata  <= '0;
    end else begin
      rd_valid <= '0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            gnt            <= sel;
            op             <= cmd_op;
            mem_address    <= cmd_address;
            mem_byteenable <= cmd_byteenable;
            mem_writedata  <= cmd_writedata;
            mem_write      <= (cmd_op == OP_WRITE);
            mem_chipselect <= 1'b1;
            waitreq[sel]   <= 1'b0;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          mem_chipselect <= 1'b0;
          mem_write      <= 1'b0;
          waitreq        <= '1;
          if (op == OP_READ) begin
            // RAM latches the address at this edge; q is valid in RDATA.
            rd_valid[gnt] <= 1'b1;
            state         <= RDATA;
          end else begin
            state <= IDLE;
          end
        end
        RDATA: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem_clken        = 1'b1;
  assign m0.waitrequest   = waitreq[0];
  assign m1.waitrequest   = waitreq[1];
  assign m0.readdatavalid = rd_valid[0];
  assign m1.readdatavalid = rd_valid[1];
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;

endmodule

// File: tb/tb_finalproject_soc_onchip_mem_arbiter.sv
// Directed bench for the on-chip RAM arbiter with a behavioural 4x32 RAM
// (registered address, unregistered q, byte-lane writes).
module tb_finalproject_soc_onchip_mem_arbiter;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic clk;
  logic reset_n;

  finalproject_soc_onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  finalproject_soc_onchip_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect;
  logic          mem_write;
  logic [DW-1:0] mem_writedata;
  logic          mem_clken;
  logic [DW-1:0] mem_readdata;

  finalproject_soc_onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .m0             (m0_if),
    .m1             (m1_if),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model
  logic [DW-1:0] ram [4];
  logic [AW-1:0] ram_addr_q;

  always @(posedge clk) begin
    if (mem_clken) begin
      ram_addr_q <= mem_address;
      if (mem_chipselect && mem_write) begin
        for (int unsigned b = 0; b < BW; b++) begin
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end
    end
  end

  assign mem_readdata = ram[ram_addr_q];

  int unsigned n_cmp;
  int unsigned n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int unsigned port, input logic rd, input logic wr,
                       input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [BW-1:0] be);
    if (port == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = addr;
      m0_if.writedata = data; m0_if.byteenable = be;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = addr;
      m1_if.writedata = data; m1_if.byteenable = be;
    end
  endtask

  task automatic release_req(input int unsigned port);
    drive(port, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wait"},  {30'd0, m1_if.waitrequest, m0_if.waitrequest}, 32'h3);
    chk({tag, "_rdv"},   {30'd0, m1_if.readdatavalid, m0_if.readdatavalid}, 32'h0);
    chk({tag, "_cs"},    {31'd0, mem_chipselect}, 32'h0);
    chk({tag, "_we"},    {31'd0, mem_write}, 32'h0);
    chk({tag, "_addr"},  {30'd0, mem_address}, 32'h0);
    chk({tag, "_be"},    {28'd0, mem_byteenable}, 32'h0);
    chk({tag, "_wdata"}, mem_writedata, 32'h0);
    chk({tag, "_clken"}, {31'd0, mem_clken}, 32'h1);
  endtask

  function automatic logic [31:0] wr_pair();
    return {30'd0, m1_if.waitrequest, m0_if.waitrequest};
  endfunction

  function automatic logic [31:0] rdv_pair();
    return {30'd0, m1_if.readdatavalid, m0_if.readdatavalid};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset_n = 1'b0;
    release_req(0);
    release_req(1);
    tick();
    tick();
    chk_reset("por");
    reset_n = 1'b1;
    tick();

    // m0 write 0xDEADBEEF to addr 2
    drive(0, 1'b0, 1'b1, 2'd2, 32'hDEADBEEF, 4'hF);
    chk("w1_pre_wait", wr_pair(), 32'h3);
    tick();
    chk("w1_issue_wait", wr_pair(), 32'h2);
    chk("w1_cs", {31'd0, mem_chipselect}, 32'h1);
    chk("w1_we", {31'd0, mem_write}, 32'h1);
    chk("w1_addr", {30'd0, mem_address}, 32'h2);
    chk("w1_wdata", mem_writedata, 32'hDEADBEEF);
    chk("w1_be", {28'd0, mem_byteenable}, 32'hF);
    tick();
    release_req(0);
    chk("w1_done_wait", wr_pair(), 32'h3);
    chk("w1_done_cs", {31'd0, mem_chipselect}, 32'h0);

    // m0 read addr 2
    drive(0, 1'b1, 1'b0, 2'd2, '0, '0);
    tick();
    chk("r1_issue_wait", wr_pair(), 32'h2);
    chk("r1_we", {31'd0, mem_write}, 32'h0);
    chk("r1_cs", {31'd0, mem_chipselect}, 32'h1);
    tick();
    release_req(0);
    chk("r1_rdv", rdv_pair(), 32'h1);
    chk("r1_data", m0_if.readdata, 32'hDEADBEEF);
    tick();
    chk("r1_rdv_end", rdv_pair(), 32'h0);

    // Byte enables: full write then m1 low-half write to addr 1
    drive(0, 1'b0, 1'b1, 2'd1, 32'h11223344, 4'hF);
    tick();
    chk("be_w0_wait", wr_pair(), 32'h2);
    tick();
    release_req(0);
    drive(1, 1'b0, 1'b1, 2'd1, 32'hAABBCCDD, 4'h3);
    tick();
    chk("be_w1_wait", wr_pair(), 32'h1);
    chk("be_w1_be", {28'd0, mem_byteenable}, 32'h3);
    tick();
    release_req(1);
    drive(0, 1'b1, 1'b0, 2'd1, '0, '0);
    tick();
    tick();
    release_req(0);
    chk("be_rdv", rdv_pair(), 32'h1);
    chk("be_data", m0_if.readdata, 32'h1122CCDD);
    tick();

    // Illegal read+write on m0 behaves as a write to addr 3
    drive(0, 1'b1, 1'b1, 2'd3, 32'h3C3C3C3C, 4'hF);
    tick();
    chk("rw_we", {31'd0, mem_write}, 32'h1);
    tick();
    release_req(0);
    chk("rw_no_rdv", rdv_pair(), 32'h0);
    // m1 writes addr 0 (leaves last grant on m1)
    drive(1, 1'b0, 1'b1, 2'd0, 32'h00A0A0A0, 4'hF);
    tick();
    chk("w_a0_wait", wr_pair(), 32'h1);
    tick();
    release_req(1);

    // Routing: m0 reads addr 0, m1 reads addr 3 at the same time
    drive(0, 1'b1, 1'b0, 2'd0, '0, '0);
    drive(1, 1'b1, 1'b0, 2'd3, '0, '0);
    tick();
    chk("rt_issue0_wait", wr_pair(), 32'h2);
    chk("rt_issue0_addr", {30'd0, mem_address}, 32'h0);
    tick();
    release_req(0);
    chk("rt_rdv0", rdv_pair(), 32'h1);
    chk("rt_data0", m0_if.readdata, 32'h00A0A0A0);
    chk("rt_data0_m1bus", m1_if.readdata, 32'h00A0A0A0);
    tick();
    chk("rt_idle_wait", wr_pair(), 32'h3);
    chk("rt_idle_rdv", rdv_pair(), 32'h0);
    tick();
    chk("rt_issue1_wait", wr_pair(), 32'h1);
    chk("rt_issue1_addr", {30'd0, mem_address}, 32'h3);
    tick();
    release_req(1);
    chk("rt_rdv1", rdv_pair(), 32'h2);
    chk("rt_data1", m1_if.readdata, 32'h3C3C3C3C);
    tick();

    // Reset in ISSUE of an m0 read (m0 becomes last grant)
    drive(0, 1'b1, 1'b0, 2'd2, '0, '0);
    tick();
    chk("rr_issue_wait", wr_pair(), 32'h2);
    reset_n = 1'b0;
    #1;
    chk_reset("rr_async");
    release_req(0);
    // Both requesters hold writes continuously from reset release
    drive(0, 1'b0, 1'b1, 2'd1, 32'h01010101, 4'hF);
    drive(1, 1'b0, 1'b1, 2'd2, 32'h02020202, 4'hF);
    tick();
    chk("rr_held_wait", wr_pair(), 32'h3);
    chk("rr_held_rdv", rdv_pair(), 32'h0);
    reset_n = 1'b1;
    chk("ct_idle0", wr_pair(), 32'h3);
    tick();
    chk("ct_g0_m0", wr_pair(), 32'h2);
    chk("ct_no_rdv", rdv_pair(), 32'h0);
    tick();
    chk("ct_gap0", wr_pair(), 32'h3);
    tick();
    chk("ct_g1_m1", wr_pair(), 32'h1);
    tick();
    chk("ct_gap1", wr_pair(), 32'h3);
    tick();
    chk("ct_g2_m0", wr_pair(), 32'h2);
    tick();
    chk("ct_gap2", wr_pair(), 32'h3);
    tick();
    chk("ct_g3_m1", wr_pair(), 32'h1);
    tick();
    release_req(0);
    release_req(1);
    tick();
    chk("ct_quiet_wait", wr_pair(), 32'h3);
    chk("ct_quiet_cs", {31'd0, mem_chipselect}, 32'h0);

    // Read back both contention writes
    drive(1, 1'b1, 1'b0, 2'd1, '0, '0);
    tick();
    tick();
    release_req(1);
    chk("ct_rb1_rdv", rdv_pair(), 32'h2);
    chk("ct_rb1_data", m1_if.readdata, 32'h01010101);
    tick();
    drive(0, 1'b1, 1'b0, 2'd2, '0, '0);
    tick();
    tick();
    release_req(0);
    chk("ct_rb2_rdv", rdv_pair(), 32'h1);
    chk("ct_rb2_data", m0_if.readdata, 32'h02020202);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
